// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encodings, default widths
// and the byte extension helper used by the load path.
package lsu_pkg;

    localparam int unsigned LSU_AW = 16;
    localparam int unsigned LSU_DW = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    function automatic logic [LSU_DW-1:0] ext_byte(input logic [7:0] b, input logic sgn);
        return {{(LSU_DW-8){sgn & b[7]}}, b};
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte lane: extracts/extends load data and builds the merged word
// for a byte store (read-modify-write of the addressed 16-bit memory word).
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [LSU_DW-1:0] rd_word,
    input  logic              is_byte,
    input  logic              is_signed,
    input  logic [7:0]        keep_hi,
    input  logic [7:0]        new_lo,
    output logic [LSU_DW-1:0] load_data,
    output logic [LSU_DW-1:0] store_merge
);

    // Load result: full word, or low byte sign/zero extended
    always_comb begin
        load_data = rd_word;
        if (is_byte) begin
            load_data = ext_byte(rd_word[7:0], is_signed);
        end else begin
            load_data = rd_word;
        end
    end

    // Byte store keeps the upper byte that was read back from memory
    always_comb begin
        store_merge = {keep_hi, new_lo};
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store sequencer in front of a 16-bit, byte-addressed data memory.
// Optional build macro MISALIGN_TRAP_EN: misaligned word accesses are rejected with resp_err.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int AW = LSU_AW,
    parameter int DW = LSU_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic          req_byte,
    input  logic          req_signed,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_err,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_wen,
    output logic          mem_ren,
    input  logic [DW-1:0] mem_dout
);

`ifdef MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    logic [1:0]    state_r;
    logic          we_r;
    logic          byte_r;
    logic          signed_r;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] wdata_r;
    logic [7:0]    rd_hi_r;
    logic [DW-1:0] rdata_r;
    logic          err_r;
    logic [DW-1:0] load_data_s;
    logic [DW-1:0] store_merge_s;

    lsu_byte_lane u_lane (
        .rd_word     (mem_dout),
        .is_byte     (byte_r),
        .is_signed   (signed_r),
        .keep_hi     (rd_hi_r),
        .new_lo      (wdata_r[7:0]),
        .load_data   (load_data_s),
        .store_merge (store_merge_s)
    );

    // FSM, request capture and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            we_r     <= 1'b0;
            byte_r   <= 1'b0;
            signed_r <= 1'b0;
            addr_r   <= {AW{1'b0}};
            wdata_r  <= {DW{1'b0}};
            rd_hi_r  <= 8'h00;
            rdata_r  <= {DW{1'b0}};
            err_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_r     <= req_we;
                        byte_r   <= req_byte;
                        signed_r <= req_signed;
                        addr_r   <= req_addr;
                        wdata_r  <= req_wdata;
                        if (TRAP_EN && !req_byte && req_addr[0]) begin
                            state_r <= ST_RESP;
                            rdata_r <= {DW{1'b0}};
                            err_r   <= 1'b1;
                        end else if (req_we && !req_byte) begin
                            state_r <= ST_WRITE;
                        end else begin
                            state_r <= ST_READ;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    // A store reaching READ is a byte store: keep the byte it must preserve
                    if (we_r) begin
                        rd_hi_r <= mem_dout[15:8];
                        state_r <= ST_WRITE;
                    end else begin
                        rdata_r <= load_data_s;
                        err_r   <= 1'b0;
                        state_r <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    rdata_r <= {DW{1'b0}};
                    err_r   <= 1'b0;
                    state_r <= ST_RESP;
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory-side decode from registered state only, stable across the negedge sample
    always_comb begin
        mem_addr = {AW{1'b0}};
        mem_din  = {DW{1'b0}};
        mem_wen  = 1'b0;
        mem_ren  = 1'b0;
        case (state_r)
            ST_READ: begin
                mem_ren  = 1'b1;
                mem_addr = addr_r;
            end
            ST_WRITE: begin
                mem_wen  = 1'b1;
                mem_addr = addr_r;
                mem_din  = byte_r ? store_merge_s : wdata_r;
            end
            default: begin
                mem_addr = {AW{1'b0}};
            end
        endcase
    end

    assign req_ready  = (state_r == ST_IDLE);
    assign resp_valid = (state_r == ST_RESP);
    assign resp_rdata = rdata_r;
    assign resp_err   = err_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a negedge-sampled byte-addressed memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic        req_byte = 1'b0;
    logic        req_signed = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    logic [15:0] req_wdata = 16'h0000;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_wen;
    logic        mem_ren;
    logic [15:0] mem_dout = 16'h0000;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          lat;
        int          nren;
        int          nwen;
        logic [15:0] din;
        logic [15:0] addr;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  mem [0:65535];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          ren_cnt = 0;
    int          wen_cnt = 0;
    bit          wen_any = 1'b0;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_byte(req_byte), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory: samples read/write on negedge, read data returned one half-cycle later
    always @(negedge clk) begin
        if (mem_wen) begin
            mem[mem_addr]         <= mem_din[7:0];
            mem[mem_addr + 16'd1] <= mem_din[15:8];
        end
        if (mem_ren) mem_dout <= {mem[mem_addr + 16'd1], mem[mem_addr]};
        else         mem_dout <= 16'h0000;
    end

    // Monitor: memory-side checks and response scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            ren_cnt = 0;
            wen_cnt = 0;
        end else begin
            if (mem_ren && mem_wen) chk("ren_wen_overlap", 32'd1, 32'd0);
            if (mem_ren) begin
                ren_cnt++;
                if (q.size() > 0) chk("ren_addr", {16'h0, mem_addr}, {16'h0, q[0].addr});
            end
            if (mem_wen) begin
                wen_cnt++;
                wen_any = 1'b1;
                if (q.size() > 0) begin
                    chk("wen_addr", {16'h0, mem_addr}, {16'h0, q[0].addr});
                    chk("wen_din", {16'h0, mem_din}, {16'h0, q[0].din});
                end
            end
            if (q.size() > 0) chk("busy_ready", {31'h0, req_ready}, 32'd0);
            if (resp_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rdata", {16'h0, resp_rdata}, {16'h0, e.rdata});
                    chk("err", {31'h0, resp_err}, {31'h0, e.err});
                    chk("latency", cyc + 1 - e.acc, e.lat);
                    chk("ren_pulses", ren_cnt, e.nren);
                    chk("wen_pulses", wen_cnt, e.nwen);
                end
                ren_cnt = 0;
                wen_cnt = 0;
            end
        end
    end

    task automatic issue(input logic we, input logic bt, input logic sg, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] rdata, input logic err,
                         input int lat, input int nren, input int nwen, input logic [15:0] din,
                         input bit push);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 32'd1, 32'd0);
        req_valid = 1'b1; req_we = we; req_byte = bt; req_signed = sg;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (push) begin
            e.rdata = rdata; e.err = err; e.lat = lat; e.nren = nren; e.nwen = nwen;
            e.din = din; e.addr = addr; e.acc = cyc;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 32'd0);
    endtask

    initial begin
        mem[16'h0010] = 8'h34; mem[16'h0011] = 8'h12; mem[16'h0012] = 8'h56;
        mem[16'h0020] = 8'h85; mem[16'h0021] = 8'h7F; mem[16'h0022] = 8'h00;
        mem[16'h0030] = 8'h00; mem[16'h0031] = 8'h00;
        mem[16'h0040] = 8'h11; mem[16'h0041] = 8'h22;

        repeat (3) @(negedge clk);
        chk("rst_ready", {31'h0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'd0);
        chk("rst_rdata", {16'h0, resp_rdata}, 32'd0);
        chk("rst_mem_ctl", {30'h0, mem_wen, mem_ren}, 32'd0);
        chk("rst_mem_addr_din", {mem_addr, mem_din}, 32'd0);
        rst_n = 1'b1;

        // we, byte, signed, addr, wdata, rdata, err, lat, nren, nwen, din, push
        issue(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b0, 2, 1, 0, 16'h0000, 1'b1);
        issue(1'b0, 1'b1, 1'b1, 16'h0020, 16'h0000, 16'hFF85, 1'b0, 2, 1, 0, 16'h0000, 1'b1);
        issue(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0085, 1'b0, 2, 1, 0, 16'h0000, 1'b1);
        issue(1'b0, 1'b1, 1'b1, 16'h0021, 16'h0000, 16'h007F, 1'b0, 2, 1, 0, 16'h0000, 1'b1);
        issue(1'b1, 1'b1, 1'b0, 16'h0010, 16'h99AB, 16'h0000, 1'b0, 3, 1, 1, 16'h12AB, 1'b1);
        issue(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h12AB, 1'b0, 2, 1, 0, 16'h0000, 1'b1);
        issue(1'b1, 1'b0, 1'b0, 16'h0030, 16'hBEEF, 16'h0000, 1'b0, 2, 0, 1, 16'hBEEF, 1'b1);
        issue(1'b0, 1'b0, 1'b0, 16'h0030, 16'h0000, 16'hBEEF, 1'b0, 2, 1, 0, 16'h0000, 1'b1);
`ifdef MISALIGN_TRAP_EN
        issue(1'b0, 1'b0, 1'b0, 16'h0011, 16'h0000, 16'h0000, 1'b1, 1, 0, 0, 16'h0000, 1'b1);
`else
        issue(1'b0, 1'b0, 1'b0, 16'h0011, 16'h0000, 16'h5612, 1'b0, 2, 1, 0, 16'h0000, 1'b1);
`endif
        drain();
        chk("mem_byte_store", {16'h0, mem[16'h0011], mem[16'h0010]}, 32'h000012AB);

        // Reset while a byte store sits in READ
        wen_any = 1'b0;
        issue(1'b1, 1'b1, 1'b0, 16'h0040, 16'h00EE, 16'h0000, 1'b0, 3, 1, 1, 16'h22EE, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'h0, req_ready}, 32'd1);
        chk("abort_ctl", {30'h0, mem_wen, mem_ren}, 32'd0);
        chk("abort_resp", {31'h0, resp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_wen", {31'h0, wen_any}, 32'd0);
        chk("abort_mem", {16'h0, mem[16'h0041], mem[16'h0040]}, 32'h00002211);

        issue(1'b1, 1'b1, 1'b0, 16'h0040, 16'h00CD, 16'h0000, 1'b0, 3, 1, 1, 16'h22CD, 1'b1);
        issue(1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'h22CD, 1'b0, 2, 1, 0, 16'h0000, 1'b1);
        issue(1'b0, 1'b1, 1'b0, 16'h0041, 16'h0000, 16'h0022, 1'b0, 2, 1, 0, 16'h0000, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
